csr_exception_unit: RTL and testbench
=====================================

# csr_exception_unit

Exception-side CSR bank for the LoongArch core. It is the responder to the pipeline control block. It receives exception and ERTN commits from the memory stage and updates CRMD, PRMD, ERA, ESTAT and BADV. It also runs the architectural timer and samples external interrupt lines. It returns ERA, EENTRY, CRMD.IE, ECFG.LIE and ESTAT.IS to the control block, and serves the write-back CSR write port and a combinational CSR read port.

## Interface
- Parameters: none. The CSR addresses are fixed: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- is_exception  in  1  exception commit this cycle
- exception_cause  in  7  [5:0] Ecode, [6] EsubCode bit 0
- exception_pc  in  32  PC of the excepting instruction
- exception_addr  in  32  faulting virtual address
- is_ertn  in  1  ERTN commit this cycle
- csr_write_en  in  1  write-back CSR write strobe
- csr_write_addr  in  14  CSR write address
- csr_write_data  in  32  CSR write data
- csr_read_addr  in  14  CSR read address
- csr_read_data  out  32  combinational read data; 0 for an unmapped address
- hw_int_i  in  8  external interrupt lines, level-sensitive
- ipi_i  in  1  inter-processor interrupt line
- ERA_PC  out  32  current ERA
- EENTRY_VA  out  32  current EENTRY, with [5:0] = 0
- ECFG_LIE  out  12  {LIE[12:11], LIE[9:0]}
- ESTAT_IS  out  12  {IS[12:11], IS[9:0]}
- CRMD_IE  out  1  current CRMD.IE
- CRMD_PLV  out  2  current privilege level

## Operation
- Register fields and software-writable bits:
  - CRMD: PLV[1:0], IE[2], DA[3].
  - PRMD: PPLV[1:0], PIE[2].
  - ECFG: LIE bits 12:11 and 9:0.
  - ESTAT: IS[1:0] only. IS[9:2], IS[11] and IS[12] are hardware-owned. Ecode[21:16] and EsubCode[22] are updated only by exceptions.
  - ERA, BADV, TID: all 32 bits.
  - EENTRY: bits [31:6].
  - TCFG: En[0], Periodic[1], InitVal[31:2].
  - TVAL: read-only.
  - TICLR: write-only pulse; reads as 0.
- Unwritable bits read 0.
- Exception entry (is_exception=1):
  - PRMD.PPLV <= CRMD.PLV and PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0 and CRMD.IE <= 0.
  - ERA <= exception_pc.
  - Ecode <= cause[5:0] and EsubCode <= cause[6].
  - BADV <= exception_addr only when Ecode is 0x8 (ADE) or 0x9 (ALE).
- ERTN (is_ertn=1, is_exception=0): CRMD.PLV <= PRMD.PPLV and CRMD.IE <= PRMD.PIE.
- Commit precedence:
  - is_exception and is_ertn in the same cycle: the exception wins and the ERTN is ignored.
  - A CSR write to a register that the exception or ERTN modifies in the same cycle is dropped entirely.
  - CSR writes to other registers in that cycle proceed.
- Interrupt sampling: every cycle IS[9:2] <= hw_int_i and IS[12] <= ipi_i. Both are registered and not software-writable.
- Timer:
  - A write to TCFG loads TVAL <= {InitVal, 2'b00} on the next edge.
  - While En=1 and TVAL != 0, TVAL decrements by 1 per cycle.
  - On the transition TVAL 1 -> 0, IS[11] is set.
  - When TVAL = 0, En = 1 and Periodic = 1, TVAL reloads {InitVal, 2'b00}. The 0 value is held for exactly one cycle and does not retrigger IS[11].
  - When TVAL = 0 and Periodic = 0, TVAL holds at 0.
  - With En = 0, TVAL holds its value.
- TICLR: writing data[0]=1 clears IS[11]. If a timer set and a TICLR clear fall in the same cycle, the set wins.
- Reset values:
  - CRMD = 0x8 (DA=1, IE=0, PLV=0).
  - All other registers = 0.
  - All outputs = 0, except that reads of CRMD return 0x8.

## Timing
- All register updates occur on the rising edge of clk. Commits and CSR writes become visible on the outputs and on csr_read_data one cycle later.
- The control block forwards same-cycle write-back values itself, so this block has no internal bypass.
- csr_read_data is purely combinational from the current register state and csr_read_addr.
- Interrupt lines reach ESTAT_IS one cycle after being sampled.
- Timer: after a TCFG write of InitVal=N with En=1, TVAL reads 4N on the next cycle. IS[11] is visible 4N cycles after that.
- Asserting rst mid-operation clears state immediately, including the timer, pending IS[11] and BADV. No commit in the reset cycle takes effect.

## Test plan
- Entry and return:
  - Setup: CRMD=0x7 (PLV=3, IE=1), then exception with cause 0x0B, pc 0x1C000100.
  - Expected: CRMD_PLV=0, CRMD_IE=0, PRMD=0x7, ERA_PC=0x1C000100, Ecode=0xB, BADV unchanged.
  - Then ERTN; expected: CRMD_PLV=3, CRMD_IE=1.
- ALE exception: cause 0x09, addr 0x80000003 -> BADV=0x80000003. A following SYS exception leaves BADV at 0x80000003.
- Simultaneous commits:
  - Exception + ERTN + CSR write to ERA = 0x1234 in one cycle, with exception_pc=0x1C000200.
  - Expected: ERA_PC=0x1C000200, CRMD.IE=0, and a same-cycle write of TID=0x55 reads back 0x55.
- Timer:
  - Single-shot: TCFG=0x0D (InitVal=3, periodic=0, En=1) -> TVAL=12 next cycle, IS[11] set 12 cycles later, TVAL holds 0.
  - Periodic: repeat with bit1=1 -> TVAL reloads 12.
  - Clear: TICLR write 1 clears IS[11]. A TICLR write on the exact set cycle leaves IS[11]=1.
- Masking and sampling:
  - Write ECFG=0xFFFFFFFF -> ECFG_LIE=0xFFF.
  - Write ESTAT=0xFFFFFFFF -> only IS[1:0] set, ESTAT_IS=0x003.
  - hw_int_i=0xA5 -> ESTAT_IS[9:2]=0xA5 one cycle later.
  - EENTRY write 0x1C00_00FF reads back 0x1C0000C0.
- Reset mid-count: assert rst with TVAL=7 and IS[11]=1 -> all outputs 0, CRMD reads 0x8, TVAL=0.

Source files
------------

// File: rtl/csr_exception_unit.sv
// Exception-side CSR bank: CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY plus the architectural timer.
// Commits from the memory stage take priority over same-cycle software writes to the registers they touch.
module csr_exception_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_exception,
  input  logic [6:0]  exception_cause,
  input  logic [31:0] exception_pc,
  input  logic [31:0] exception_addr,
  input  logic        is_ertn,
  input  logic        csr_write_en,
  input  logic [13:0] csr_write_addr,
  input  logic [31:0] csr_write_data,
  input  logic [13:0] csr_read_addr,
  output logic [31:0] csr_read_data,
  input  logic [7:0]  hw_int_i,
  input  logic        ipi_i,
  output logic [31:0] ERA_PC,
  output logic [31:0] EENTRY_VA,
  output logic [11:0] ECFG_LIE,
  output logic [11:0] ESTAT_IS,
  output logic        CRMD_IE,
  output logic [1:0]  CRMD_PLV
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00C;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;

  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic        crmd_da;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [11:0] ecfg_lie;   // packed as {LIE[12:11], LIE[9:0]}
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_timer;
  logic        is_ipi;
  logic [5:0]  ecode;
  logic        esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [31:0] tid;
  logic        tcfg_en;
  logic        tcfg_periodic;
  logic [29:0] tcfg_init;
  logic [31:0] tval;

  logic exc;
  logic ertn;
  logic badv_hit;
  logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv;
  logic wr_eentry, wr_tid, wr_tcfg, wr_ticlr;
  logic [31:0] tval_next;
  logic timer_fire;

  assign exc      = is_exception;
  assign ertn     = is_ertn & ~is_exception;
  assign badv_hit = exc & ((exception_cause[5:0] == 6'h08) | (exception_cause[5:0] == 6'h09));

  // Writes colliding with a commit that modifies the same register are dropped whole.
  assign wr_crmd   = csr_write_en & (csr_write_addr == ADDR_CRMD) & ~exc & ~ertn;
  assign wr_prmd   = csr_write_en & (csr_write_addr == ADDR_PRMD) & ~exc;
  assign wr_ecfg   = csr_write_en & (csr_write_addr == ADDR_ECFG);
  assign wr_estat  = csr_write_en & (csr_write_addr == ADDR_ESTAT) & ~exc;
  assign wr_era    = csr_write_en & (csr_write_addr == ADDR_ERA) & ~exc;
  assign wr_badv   = csr_write_en & (csr_write_addr == ADDR_BADV) & ~badv_hit;
  assign wr_eentry = csr_write_en & (csr_write_addr == ADDR_EENTRY);
  assign wr_tid    = csr_write_en & (csr_write_addr == ADDR_TID);
  assign wr_tcfg   = csr_write_en & (csr_write_addr == ADDR_TCFG);
  assign wr_ticlr  = csr_write_en & (csr_write_addr == ADDR_TICLR) & csr_write_data[0];

  always_comb begin
    tval_next  = tval;
    timer_fire = 1'b0;
    if (wr_tcfg) begin
      tval_next = {csr_write_data[31:2], 2'b00};
    end else if (tcfg_en) begin
      if (tval != 32'd0) begin
        tval_next  = tval - 32'd1;
        timer_fire = (tval == 32'd1);
      end else if (tcfg_periodic) begin
        tval_next = {tcfg_init, 2'b00};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crmd_plv      <= 2'd0;
      crmd_ie       <= 1'b0;
      crmd_da       <= 1'b1;
      prmd_pplv     <= 2'd0;
      prmd_pie      <= 1'b0;
      ecfg_lie      <= 12'd0;
      is_sw         <= 2'd0;
      is_hw         <= 8'd0;
      is_timer      <= 1'b0;
      is_ipi        <= 1'b0;
      ecode         <= 6'd0;
      esubcode      <= 1'b0;
      era           <= 32'd0;
      badv          <= 32'd0;
      eentry        <= 26'd0;
      tid           <= 32'd0;
      tcfg_en       <= 1'b0;
      tcfg_periodic <= 1'b0;
      tcfg_init     <= 30'd0;
      tval          <= 32'd0;
    end else begin
      if (exc) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
        crmd_plv  <= 2'd0;
        crmd_ie   <= 1'b0;
        era       <= exception_pc;
        ecode     <= exception_cause[5:0];
        esubcode  <= exception_cause[6];
        if (badv_hit) badv <= exception_addr;
      end else if (ertn) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end

      if (wr_crmd) begin
        crmd_plv <= csr_write_data[1:0];
        crmd_ie  <= csr_write_data[2];
        crmd_da  <= csr_write_data[3];
      end
      if (wr_prmd) begin
        prmd_pplv <= csr_write_data[1:0];
        prmd_pie  <= csr_write_data[2];
      end
      if (wr_ecfg)   ecfg_lie <= {csr_write_data[12:11], csr_write_data[9:0]};
      if (wr_estat)  is_sw    <= csr_write_data[1:0];
      if (wr_era)    era      <= csr_write_data;
      if (wr_badv)   badv     <= csr_write_data;
      if (wr_eentry) eentry   <= csr_write_data[31:6];
      if (wr_tid)    tid      <= csr_write_data;
      if (wr_tcfg) begin
        tcfg_en       <= csr_write_data[0];
        tcfg_periodic <= csr_write_data[1];
        tcfg_init     <= csr_write_data[31:2];
      end

      is_hw <= hw_int_i;
      is_ipi <= ipi_i;
      tval <= tval_next;
      // A timer expiry outranks a same-cycle TICLR.
      if (timer_fire)     is_timer <= 1'b1;
      else if (wr_ticlr)  is_timer <= 1'b0;
    end
  end

  always_comb begin
    csr_read_data = 32'd0;
    case (csr_read_addr)
      ADDR_CRMD:   csr_read_data = {28'd0, crmd_da, crmd_ie, crmd_plv};
      ADDR_PRMD:   csr_read_data = {29'd0, prmd_pie, prmd_pplv};
      ADDR_ECFG:   csr_read_data = {19'd0, ecfg_lie[11:10], 1'b0, ecfg_lie[9:0]};
      ADDR_ESTAT:  csr_read_data = {9'd0, esubcode, ecode, 3'd0, is_ipi, is_timer, 1'b0, is_hw, is_sw};
      ADDR_ERA:    csr_read_data = era;
      ADDR_BADV:   csr_read_data = badv;
      ADDR_EENTRY: csr_read_data = {eentry, 6'd0};
      ADDR_TID:    csr_read_data = tid;
      ADDR_TCFG:   csr_read_data = {tcfg_init, tcfg_periodic, tcfg_en};
      ADDR_TVAL:   csr_read_data = tval;
      default:     csr_read_data = 32'd0;
    endcase
  end

  assign ERA_PC    = era;
  assign EENTRY_VA = {eentry, 6'd0};
  assign ECFG_LIE  = ecfg_lie;
  assign ESTAT_IS  = {is_ipi, is_timer, is_hw, is_sw};
  assign CRMD_IE   = crmd_ie;
  assign CRMD_PLV  = crmd_plv;

endmodule

// File: tb/tb_csr_exception_unit.sv
// Directed and randomized checks of csr_exception_unit against a register-level reference model.
module tb_csr_exception_unit;

  localparam logic [13:0] A_CRMD = 14'h000, A_PRMD = 14'h001, A_ECFG = 14'h004, A_ESTAT = 14'h005;
  localparam logic [13:0] A_ERA = 14'h006, A_BADV = 14'h007, A_EENTRY = 14'h00C, A_TID = 14'h040;
  localparam logic [13:0] A_TCFG = 14'h041, A_TVAL = 14'h042, A_TICLR = 14'h044;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_exception;
  logic [6:0]  exception_cause;
  logic [31:0] exception_pc;
  logic [31:0] exception_addr;
  logic        is_ertn;
  logic        csr_write_en;
  logic [13:0] csr_write_addr;
  logic [31:0] csr_write_data;
  logic [13:0] csr_read_addr;
  logic [31:0] csr_read_data;
  logic [7:0]  hw_int_i;
  logic        ipi_i;
  logic [31:0] ERA_PC;
  logic [31:0] EENTRY_VA;
  logic [11:0] ECFG_LIE;
  logic [11:0] ESTAT_IS;
  logic        CRMD_IE;
  logic [1:0]  CRMD_PLV;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Architectural register images, holding exactly the bits a read returns.
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
  logic [13:0] addrs [12];

  csr_exception_unit dut (
    .clk(clk), .rst(rst),
    .is_exception(is_exception), .exception_cause(exception_cause),
    .exception_pc(exception_pc), .exception_addr(exception_addr),
    .is_ertn(is_ertn),
    .csr_write_en(csr_write_en), .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data),
    .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
    .hw_int_i(hw_int_i), .ipi_i(ipi_i),
    .ERA_PC(ERA_PC), .EENTRY_VA(EENTRY_VA), .ECFG_LIE(ECFG_LIE), .ESTAT_IS(ESTAT_IS),
    .CRMD_IE(CRMD_IE), .CRMD_PLV(CRMD_PLV)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [13:0] a);
    case (a)
      A_CRMD:   return m_crmd;
      A_PRMD:   return m_prmd;
      A_ECFG:   return m_ecfg;
      A_ESTAT:  return m_estat;
      A_ERA:    return m_era;
      A_BADV:   return m_badv;
      A_EENTRY: return m_eentry;
      A_TID:    return m_tid;
      A_TCFG:   return m_tcfg;
      A_TVAL:   return m_tval;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [11:0] pack12(input logic [31:0] v);
    return {v[12:11], v[9:0]};
  endfunction

  task automatic model_reset();
    m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0;
    m_badv = 0; m_eentry = 0; m_tid = 0; m_tcfg = 0; m_tval = 0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    csr_read_addr = a;
    #1;
    d = csr_read_data;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".era"},    ERA_PC, m_era);
    check({tag, ".eentry"}, EENTRY_VA, m_eentry);
    check({tag, ".lie"},    {20'd0, ECFG_LIE}, {20'd0, pack12(m_ecfg)});
    check({tag, ".is"},     {20'd0, ESTAT_IS}, {20'd0, pack12(m_estat)});
    check({tag, ".ie"},     {31'd0, CRMD_IE}, {31'd0, m_crmd[2]});
    check({tag, ".plv"},    {30'd0, CRMD_PLV}, {30'd0, m_crmd[1:0]});
  endtask

  // One clock: derive the model's next state from the driven inputs, clock, compare.
  task automatic step(input string tag);
    logic exc, ertn, badv_hit, fire, clr, tcfg_wr;
    logic [31:0] c, p, ec, es, er, bv, ee, td, tc, tv, d, got;
    exc = is_exception;
    ertn = is_ertn && !is_exception;
    badv_hit = exc && (exception_cause[5:0] == 6'h8 || exception_cause[5:0] == 6'h9);
    c = m_crmd; p = m_prmd; ec = m_ecfg; es = m_estat; er = m_era;
    bv = m_badv; ee = m_eentry; td = m_tid; tc = m_tcfg; tv = m_tval;
    fire = 0; clr = 0; tcfg_wr = 0;
    if (exc) begin
      p = m_crmd & 32'h7;
      c = m_crmd & ~32'h7;
      er = exception_pc;
      es = (es & ~32'h007F_0000) | {9'd0, exception_cause, 16'd0};
      if (badv_hit) bv = exception_addr;
    end else if (ertn) begin
      c = (m_crmd & ~32'h7) | (m_prmd & 32'h7);
    end
    if (csr_write_en) begin
      d = csr_write_data;
      case (csr_write_addr)
        A_CRMD:   if (!exc && !ertn) c = d & 32'hF;
        A_PRMD:   if (!exc) p = d & 32'h7;
        A_ECFG:   ec = d & 32'h1BFF;
        A_ESTAT:  if (!exc) es = (es & ~32'h3) | (d & 32'h3);
        A_ERA:    if (!exc) er = d;
        A_BADV:   if (!badv_hit) bv = d;
        A_EENTRY: ee = d & 32'hFFFF_FFC0;
        A_TID:    td = d;
        A_TCFG:   begin tc = d; tcfg_wr = 1; end
        A_TICLR:  clr = d[0];
        default:  ;
      endcase
    end
    if (tcfg_wr) tv = csr_write_data & ~32'h3;
    else if (m_tcfg[0]) begin
      if (m_tval != 0) begin
        tv = m_tval - 1;
        fire = (m_tval == 1);
      end else if (m_tcfg[1]) begin
        tv = m_tcfg & ~32'h3;
      end
    end
    es[9:2] = hw_int_i;
    es[12] = ipi_i;
    if (fire) es[11] = 1'b1;
    else if (clr) es[11] = 1'b0;

    $display("[TB] cyc %0d %s exc=%0b ertn=%0b we=%0b wa=%h wd=%h", cyc, tag, is_exception,
             is_ertn, csr_write_en, csr_write_addr, csr_write_data);
    @(posedge clk);
    #1;
    cyc++;
    m_crmd = c; m_prmd = p; m_ecfg = ec; m_estat = es; m_era = er;
    m_badv = bv; m_eentry = ee; m_tid = td; m_tcfg = tc; m_tval = tv;
    is_exception = 0; is_ertn = 0; csr_write_en = 0;
    check_outputs(tag);
    rd(addrs[cyc % 12], got);
    check({tag, ".rd"}, got, model_read(addrs[cyc % 12]));
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_write_en = 1; csr_write_addr = a; csr_write_data = d;
  endtask

  task automatic exc_in(input logic [6:0] cause, input logic [31:0] pc, input logic [31:0] addr);
    is_exception = 1; exception_cause = cause; exception_pc = pc; exception_addr = addr;
  endtask

  initial begin
    logic [31:0] v;
    addrs = '{A_CRMD, A_PRMD, A_ECFG, A_ESTAT, A_ERA, A_BADV, A_EENTRY, A_TID,
              A_TCFG, A_TVAL, A_TICLR, 14'h03F};
    rst = 1; is_exception = 0; exception_cause = 0; exception_pc = 0; exception_addr = 0;
    is_ertn = 0; csr_write_en = 0; csr_write_addr = 0; csr_write_data = 0;
    csr_read_addr = 0; hw_int_i = 0; ipi_i = 0;
    model_reset();
    #2;
    check_outputs("reset");
    rd(A_CRMD, v); check("reset.crmd", v, 32'h8);
    rd(A_TVAL, v); check("reset.tval", v, 32'h0);
    @(posedge clk); #1; rst = 0;

    // Entry and return
    wr(A_CRMD, 32'h7); step("crmd_wr");
    exc_in(7'h0B, 32'h1C00_0100, 32'hDEAD_BEEF); step("exc_sys");
    check("entry.plv", {30'd0, CRMD_PLV}, 32'd0);
    check("entry.ie", {31'd0, CRMD_IE}, 32'd0);
    check("entry.era", ERA_PC, 32'h1C00_0100);
    rd(A_PRMD, v); check("entry.prmd", v, 32'h7);
    rd(A_ESTAT, v); check("entry.ecode", {26'd0, v[21:16]}, 32'hB);
    rd(A_BADV, v); check("entry.badv", v, 32'h0);
    is_ertn = 1; step("ertn");
    check("ertn.plv", {30'd0, CRMD_PLV}, 32'd3);
    check("ertn.ie", {31'd0, CRMD_IE}, 32'd1);

    // ALE then SYS: BADV only follows address faults
    exc_in(7'h09, 32'h1C00_0104, 32'h8000_0003); step("exc_ale");
    rd(A_BADV, v); check("ale.badv", v, 32'h8000_0003);
    exc_in(7'h0B, 32'h1C00_0108, 32'h1111_2222); step("exc_sys2");
    rd(A_BADV, v); check("sys.badv", v, 32'h8000_0003);

    // Simultaneous commits
    wr(A_CRMD, 32'h7); step("crmd_wr2");
    exc_in(7'h0B, 32'h1C00_0200, 32'h0); is_ertn = 1; wr(A_ERA, 32'h1234); step("exc_ertn_era");
    check("simul.era", ERA_PC, 32'h1C00_0200);
    check("simul.ie", {31'd0, CRMD_IE}, 32'd0);
    exc_in(7'h0B, 32'h1C00_0300, 32'h0); wr(A_TID, 32'h55); step("exc_tid");
    rd(A_TID, v); check("simul.tid", v, 32'h55);

    // Single-shot timer
    wr(A_TCFG, 32'h0D); step("tcfg_once");
    rd(A_TVAL, v); check("once.load", v, 32'd12);
    repeat (11) step("count");
    check("once.pre_is11", {31'd0, ESTAT_IS[10]}, 32'd0);
    step("count");
    check("once.is11", {31'd0, ESTAT_IS[10]}, 32'd1);
    repeat (2) step("count");
    rd(A_TVAL, v); check("once.hold0", v, 32'd0);
    wr(A_TICLR, 32'h1); step("ticlr");
    check("ticlr.clear", {31'd0, ESTAT_IS[10]}, 32'd0);

    // Periodic timer and TICLR racing the set
    wr(A_TCFG, 32'h0F); step("tcfg_per");
    repeat (12) step("count");
    rd(A_TVAL, v); check("per.zero", v, 32'd0);
    check("per.is11", {31'd0, ESTAT_IS[10]}, 32'd1);
    step("count");
    rd(A_TVAL, v); check("per.reload", v, 32'd12);
    wr(A_TICLR, 32'h1); step("ticlr");
    repeat (10) step("count");
    rd(A_TVAL, v); check("per.at1", v, 32'd1);
    wr(A_TICLR, 32'h1); step("ticlr_race");
    check("race.is11", {31'd0, ESTAT_IS[10]}, 32'd1);

    // Masking and sampling
    wr(A_TCFG, 32'h0); step("tcfg_off");
    wr(A_TICLR, 32'h1); step("ticlr");
    wr(A_ECFG, 32'hFFFF_FFFF); step("ecfg_all");
    check("ecfg.lie", {20'd0, ECFG_LIE}, 32'hFFF);
    wr(A_ESTAT, 32'hFFFF_FFFF); step("estat_all");
    check("estat.is", {20'd0, ESTAT_IS}, 32'h003);
    hw_int_i = 8'hA5; step("hw_int");
    check("hwint.is", {24'd0, ESTAT_IS[9:2]}, 32'hA5);
    hw_int_i = 8'h00;
    wr(A_EENTRY, 32'h1C00_00FF); step("eentry");
    rd(A_EENTRY, v); check("eentry.rd", v, 32'h1C00_00C0);

    // Reset mid-count
    wr(A_TCFG, 32'h0D); step("tcfg_once");
    repeat (12) step("count");
    wr(A_TCFG, 32'h09); step("tcfg_2");
    step("count");
    rd(A_TVAL, v); check("prerst.tval", v, 32'd7);
    check("prerst.is11", {31'd0, ESTAT_IS[10]}, 32'd1);
    rst = 1;
    model_reset();
    #1;
    check_outputs("midrst");
    check("midrst.is_zero", {20'd0, ESTAT_IS}, 32'd0);
    rd(A_CRMD, v); check("midrst.crmd", v, 32'h8);
    rd(A_TVAL, v); check("midrst.tval", v, 32'h0);
    rd(A_BADV, v); check("midrst.badv", v, 32'h0);
    rst = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [13:0] a;
      logic [3:0] sel;
      is_exception = ($urandom_range(0, 7) == 0);
      is_ertn = ($urandom_range(0, 7) == 0);
      sel = 4'($urandom_range(0, 3));
      exception_cause = {1'($urandom_range(0, 1)),
                         (sel == 0) ? 6'h08 : (sel == 1) ? 6'h09 : (sel == 2) ? 6'h0B : 6'($urandom)};
      exception_pc = $urandom;
      exception_addr = $urandom;
      a = addrs[$urandom_range(0, 11)];
      csr_write_en = 1'($urandom_range(0, 1));
      csr_write_addr = a;
      csr_write_data = (a == A_TCFG) ? (($urandom_range(0, 5) << 2) | $urandom_range(0, 3)) : $urandom;
      hw_int_i = 8'($urandom);
      ipi_i = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
